div_unit: RTL and testbench



---
 rtl/div_if.sv | 30 +++
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// ============================================================================
// Module   : div_if
// Brief    : Request/result bundle between the EX stage and the divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Iterative restoring DIV/DIVU, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_W = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     dividend_q, dividend_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quot_q, quot_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  w_sign1, w_sign2;
    logic [DATA_W-1:0]     w_mag1, w_mag2;
    logic [DATA_W:0]       w_shift, w_diff;
    logic                  w_keep;
    logic [DATA_W-1:0]     w_rem_next, w_quot_next;
    logic [DATA_W-1:0]     w_quot_fix, w_rem_fix;

    assign w_sign1 = bus.signed_i & bus.opdata1_i[DATA_W-1];
    assign w_sign2 = bus.signed_i & bus.opdata2_i[DATA_W-1];
    assign w_mag1  = w_sign1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign w_mag2  = w_sign2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    // The stored remainder is always below the divisor, so DATA_W bits hold it;
    // only the shifted trial value needs the extra bit.
    assign w_shift     = {rem_q, dividend_q[DATA_W-1]};
    assign w_diff      = w_shift - {1'b0, divisor_q};
    assign w_keep      = ~w_diff[DATA_W];
    assign w_rem_next  = w_keep ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quot_next = {quot_q[DATA_W-2:0], w_keep};
    assign w_quot_fix  = neg_quot_q ? (~w_quot_next + 1'b1) : w_quot_next;
    assign w_rem_fix   = neg_rem_q  ? (~w_rem_next  + 1'b1) : w_rem_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    dividend_d = w_mag1;
                    divisor_d  = w_mag2;
                    neg_quot_d = w_sign1 ^ w_sign2;
                    neg_rem_d  = w_sign1;
                    rem_d      = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    state_d    = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                result_d = '0;
                if (bus.annul_i) begin
                    ready_d = 1'b0;
                    state_d = S_FREE;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_END;
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_FREE;
                end else begin
                    rem_d      = w_rem_next;
                    quot_d     = w_quot_next;
                    dividend_d = {dividend_q[DATA_W-2:0], 1'b0};
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        result_d = {w_rem_fix, w_quot_fix};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_FREE;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
                state_d  = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed scoreboard bench for div_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [2*DATA_W-1:0] sb_q[$];
    logic [2*DATA_W-1:0] hold_val;
    bit   saw_ready;

    div_if #(.DATA_W(DATA_W)) bus ();

    div_unit #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drive a request and clock the accepting edge (edge 0).
    task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
        if (push) sb_q.push_back(model(sgn, a, b));
        tick();
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int n = 0;
        logic [63:0] exp;
        do begin
            tick();
            n++;
        end while (!bus.ready_o && n < 40);
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_result"}, bus.result_o, exp);
        end else begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end
    endtask

    task automatic release_op(input string tag);
        bus.start_i = 1'b0;
        tick();
        chk({tag, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
        chk({tag, "_rel_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        tick();
        tick();
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        start_op(1'b0, 32'd7, 32'd2, 1'b1);
        wait_result("udiv_7_2", 32);
        chk("udiv_7_2_const", bus.result_o, 64'h00000001_00000003);
        release_op("udiv_7_2");

        start_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_result("sdiv_m7_2", 32);
        chk("sdiv_m7_2_const", bus.result_o, 64'hFFFFFFFF_FFFFFFFD);
        release_op("sdiv_m7_2");

        start_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
        wait_result("sdiv_7_m2", 32);
        release_op("sdiv_7_m2");

        start_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
        wait_result("udiv_max_1", 32);
        release_op("udiv_max_1");

        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_result("sdiv_ovf", 32);
        chk("sdiv_ovf_const", bus.result_o, 64'h00000000_80000000);
        release_op("sdiv_ovf");

        start_op(1'b0, 32'h1234, 32'd0, 1'b1);
        wait_result("byzero", 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("byzero_hold_ready", 64'(bus.ready_o), 64'd1);
            chk("byzero_hold_result", bus.result_o, 64'd0);
        end
        release_op("byzero");

        // Annul mid-operation: the unit must abandon the divide with nothing visible.
        start_op(1'b0, 32'd100, 32'd7, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        chk("annul_ready", 64'(bus.ready_o), 64'd0);
        chk("annul_result", bus.result_o, 64'd0);
        saw_ready = 1'b0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (bus.ready_o) saw_ready = 1'b1;
        end
        chk("annul_never_ready", 64'(saw_ready), 64'd0);
        start_op(1'b0, 32'd100, 32'd7, 1'b1);
        wait_result("after_annul", 32);
        chk("after_annul_const", bus.result_o, 64'h00000002_0000000E);
        release_op("after_annul");

        // Reset at edge 20, then a fresh request must be accepted on the next edge.
        start_op(1'b1, 32'hFFFFFF00, 32'd3, 1'b0);
        for (int i = 1; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 64'(bus.ready_o), 64'd0);
        chk("midrst_result", bus.result_o, 64'd0);
        start_op(1'b0, 32'd1000, 32'd9, 1'b1);
        for (int i = 1; i < 12; i++) tick();
        bus.opdata1_i = 32'hDEADBEEF;
        bus.opdata2_i = 32'd5;
        bus.signed_i  = 1'b1;
        hold_val = 64'h0000000000000000;
        wait_result("latched_ops", 21);
        chk("latched_ops_const", bus.result_o, 64'h00000001_0000006F);
        release_op("latched_ops");

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
